// File: rtl/wb_load_align_unit.sv
// Registered writeback stage: retires ALU/store results directly and waits for load data,
// aligning and extending the addressed lane. Optional macro WB_ALIGN_EXC_EN traps misaligned loads.
module wb_load_align_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mem_read_flag,
  input  logic                      mem_write_flag,
  input  logic                      mem_sign_ext_flag,
  input  logic [1:0]                mem_size,
  input  logic [DATA_WIDTH-1:0]     result_in,
  input  logic                      reg_write_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
  input  logic [ADDR_WIDTH-1:0]     current_pc_addr_in,
  input  logic                      ram_rvalid,
  input  logic [DATA_WIDTH-1:0]     ram_read_data,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      reg_write_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
  output logic                      retire_valid,
  output logic                      bus_err,
  output logic                      align_exc,
  output logic                      debug_reg_write_en,
  output logic [ADDR_WIDTH-1:0]     debug_pc_addr_out
);
  localparam int OFF_W   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W   = $clog2(DATA_WIDTH);
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [OFF_W-1:0]          ld_off;
  logic [1:0]                ld_size;
  logic                      ld_sign, ld_wen, ld_misal;
  logic [REG_ADDR_WIDTH-1:0] ld_addr;
  logic [ADDR_WIDTH-1:0]     ld_pc;

  logic                      retire_nxt, wen_nxt, bus_err_nxt;
  logic [DATA_WIDTH-1:0]     result_nxt;
  logic [REG_ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH-1:0]     pc_nxt;
  logic [OFF_W-1:0]          in_off;
  logic                      in_misal;

  function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
    int nbytes;
    nbytes = 1 << size;
    if (nbytes * 8 > DATA_WIDTH) return 1'b1;
    return ((int'(off) & (nbytes - 1)) != 0);
  endfunction

  // Shift the addressed lane down to bit 0, then fill above the field width.
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] data,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size, input logic sign);
    logic [DATA_WIDTH-1:0] shifted, res;
    logic [IDX_W-1:0]      top;
    logic                  fill;
    int                    n;
    shifted = data >> {off, 3'b000};
    n = 8 << size;
    if (n > DATA_WIDTH) n = DATA_WIDTH;
    top  = IDX_W'(n - 1);
    fill = sign & shifted[top];
    for (int i = 0; i < DATA_WIDTH; i++) res[i] = (i < n) ? shifted[i] : fill;
    return res;
  endfunction

  assign in_off             = result_in[OFF_W-1:0];
  assign in_misal           = is_misaligned(in_off, mem_size);
  assign in_ready           = (state == IDLE);
  assign debug_reg_write_en = reg_write_en_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      result_out         <= '0;
      reg_write_en_out   <= 1'b0;
      reg_write_addr_out <= '0;
      retire_valid       <= 1'b0;
      bus_err            <= 1'b0;
      debug_pc_addr_out  <= '0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      result_out         <= result_nxt;
      reg_write_en_out   <= wen_nxt;
      reg_write_addr_out <= addr_nxt;
      retire_valid       <= retire_nxt;
      bus_err            <= bus_err_nxt;
      debug_pc_addr_out  <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_off   <= '0;
      ld_size  <= '0;
      ld_sign  <= 1'b0;
      ld_wen   <= 1'b0;
      ld_misal <= 1'b0;
      ld_addr  <= '0;
      ld_pc    <= '0;
    end else if (state == IDLE && in_valid && mem_read_flag) begin
      ld_off   <= in_off;
      ld_size  <= mem_size;
      ld_sign  <= mem_sign_ext_flag;
      ld_wen   <= reg_write_en_in;
      ld_misal <= in_misal;
      ld_addr  <= reg_write_addr_in;
      ld_pc    <= current_pc_addr_in;
    end
  end

`ifdef WB_ALIGN_EXC_EN
  logic align_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_exc <= 1'b0;
    else        align_exc <= align_nxt;
  end
`else
  assign align_exc = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    retire_nxt  = 1'b0;
    wen_nxt     = 1'b0;
    bus_err_nxt = 1'b0;
    result_nxt  = result_out;
    addr_nxt    = reg_write_addr_out;
    pc_nxt      = debug_pc_addr_out;
`ifdef WB_ALIGN_EXC_EN
    align_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (mem_read_flag) begin
`ifdef WB_ALIGN_EXC_EN
            if (in_misal) begin
              retire_nxt = 1'b1;
              align_nxt  = 1'b1;
              result_nxt = '0;
              addr_nxt   = reg_write_addr_in;
              pc_nxt     = current_pc_addr_in;
            end else
`endif
            begin
              state_nxt = WAIT;
              cnt_nxt   = '0;
            end
          end else begin
            retire_nxt = 1'b1;
            wen_nxt    = mem_write_flag ? 1'b0 : reg_write_en_in;
            result_nxt = mem_write_flag ? '0 : result_in;
            addr_nxt   = reg_write_addr_in;
            pc_nxt     = current_pc_addr_in;
          end
        end
      end
      WAIT: begin
        if (ram_rvalid) begin
          state_nxt  = IDLE;
          retire_nxt = 1'b1;
          wen_nxt    = ld_wen;
          result_nxt = ld_misal ? '0 : extract(ram_read_data, ld_off, ld_size, ld_sign);
          addr_nxt   = ld_addr;
          pc_nxt     = ld_pc;
        end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
          state_nxt   = IDLE;
          retire_nxt  = 1'b1;
          bus_err_nxt = 1'b1;
          result_nxt  = '0;
          addr_nxt    = ld_addr;
          pc_nxt      = ld_pc;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
